// File: rtl/vend_credit_if.sv
// Coin-side inputs and actuator-side outputs of the vending credit controller.
// The master drives the coin acceptor inputs; the controller owns the outputs.
interface vend_credit_if #(
    parameter int CREDIT_W = 5,
    parameter int STOCK_W  = 4
);
    logic                coin_valid;
    logic [1:0]          coin;
    logic                cancel;
    logic                restock;
    logic                dispense;
    logic                change_pulse;
    logic                coin_reject;
    logic [CREDIT_W-1:0] credit;
    logic [STOCK_W-1:0]  stock;
    logic                sold_out;
    logic                busy;

    modport master (
        output coin_valid, coin, cancel, restock,
        input  dispense, change_pulse, coin_reject, credit, stock, sold_out, busy
    );

    modport slave (
        input  coin_valid, coin, cancel, restock,
        output dispense, change_pulse, coin_reject, credit, stock, sold_out, busy
    );
endinterface

// File: rtl/vend_credit_ctrl.sv
// Vending controller: accumulates coin credit, vends one item at PRICE,
// pays back remainder/cancelled credit as unit change pulses, tracks stock.
module vend_credit_ctrl #(
    parameter int PRICE      = 4,
    parameter int MAX_CREDIT = 16,
    parameter int CREDIT_W   = 5,
    parameter int STOCK_INIT = 8,
    parameter int STOCK_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    vend_credit_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    localparam logic [CREDIT_W:0]   L_MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   L_PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [CREDIT_W-1:0] L_PRICE   = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] L_ONE_C   = CREDIT_W'(1);
    localparam logic [STOCK_W-1:0]  L_STOCK   = STOCK_W'(STOCK_INIT);
    localparam logic [STOCK_W-1:0]  L_ONE_S   = STOCK_W'(1);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [STOCK_W-1:0]  r_stock;
    logic                r_coin_reject;

    logic [CREDIT_W:0]   w_value;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_present;
    logic                w_open;
    logic                w_sold_out;
    logic                w_accept;

    // Coin code to credit units; the one-bit-wider result keeps the overflow test exact.
    function automatic logic [CREDIT_W:0] coin_value(input logic [1:0] code);
        logic [CREDIT_W:0] v;
        case (code)
            2'b01:   v = (CREDIT_W+1)'(1);
            2'b10:   v = (CREDIT_W+1)'(2);
            2'b11:   v = (CREDIT_W+1)'(4);
            default: v = (CREDIT_W+1)'(0);
        endcase
        return v;
    endfunction

    // Coin acceptance decision for the current cycle.
    always_comb begin
        w_value        = coin_value(bus.coin);
        w_sum          = {1'b0, r_credit} + w_value;
        w_coin_present = bus.coin_valid && (bus.coin != 2'b00);
        w_open         = (r_state == S_IDLE) || (r_state == S_CREDIT);
        w_sold_out     = (r_stock == '0);
        w_accept       = w_open && w_coin_present && !w_sold_out &&
                         !bus.cancel && (w_sum <= L_MAX_W);
    end

    // Controller state, credit, stock and reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_credit      <= '0;
            r_stock       <= L_STOCK;
            r_coin_reject <= 1'b0;
        end else begin
            r_coin_reject <= w_coin_present && !w_accept;
            case (r_state)
                S_IDLE, S_CREDIT: begin
                    // Restock shares the edge with a coin; the coin saw the old stock.
                    if ((r_state == S_IDLE) && bus.restock) begin
                        r_stock <= L_STOCK;
                    end
                    if (w_accept) begin
                        r_credit <= w_sum[CREDIT_W-1:0];
                        r_state  <= (w_sum >= L_PRICE_W) ? S_VEND : S_CREDIT;
                    end else if ((r_state == S_CREDIT) && bus.cancel) begin
                        r_state <= S_CHANGE;
                    end
                end
                S_VEND: begin
                    r_credit <= r_credit - L_PRICE;
                    r_stock  <= r_stock - L_ONE_S;
                    r_state  <= (r_credit == L_PRICE) ? S_IDLE : S_CHANGE;
                end
                S_CHANGE: begin
                    r_credit <= r_credit - L_ONE_C;
                    if (r_credit <= L_ONE_C) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_credit <= '0;
                end
            endcase
        end
    end

    assign bus.dispense     = (r_state == S_VEND);
    assign bus.change_pulse = (r_state == S_CHANGE);
    assign bus.busy         = (r_state == S_VEND) || (r_state == S_CHANGE);
    assign bus.coin_reject  = r_coin_reject;
    assign bus.credit       = r_credit;
    assign bus.stock        = r_stock;
    assign bus.sold_out     = (r_stock == '0);

endmodule

// File: tb/tb_vend_credit_ctrl.sv
// Bench for vend_credit_ctrl: a default unit and a STOCK_INIT=1 unit share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_vend_credit_ctrl;

    localparam int PRICE = 4;
    localparam int MAXC  = 16;
    localparam int CW    = 5;
    localparam int SW    = 4;

    logic clk;
    logic rst;

    vend_credit_if #(.CREDIT_W(CW), .STOCK_W(SW)) bus0 ();
    vend_credit_if #(.CREDIT_W(CW), .STOCK_W(SW)) bus1 ();

    vend_credit_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW),
                       .STOCK_INIT(8), .STOCK_W(SW))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    vend_credit_ctrl #(.PRICE(PRICE), .MAX_CREDIT(MAXC), .CREDIT_W(CW),
                       .STOCK_INIT(1), .STOCK_W(SW))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Model: credit held, stock, item being dispensed, change being paid, reject pending.
    int si[2] = '{8, 1};
    int m_credit[2];
    int m_stock[2];
    bit m_vend[2];
    bit m_pay[2];
    bit m_rej[2];
    int disp_cnt[2];
    int chg_cnt[2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_tick(input int k, input logic cv, input logic [1:0] c,
                              input logic can, input logic rs, input logic rr);
        int val;
        bit present;
        bit accept;
        bit idle;
        val     = (c == 2'd1) ? 1 : (c == 2'd2) ? 2 : (c == 2'd3) ? 4 : 0;
        present = cv && (c != 2'd0);
        accept  = 1'b0;
        if (rr) begin
            m_credit[k] = 0;
            m_stock[k]  = si[k];
            m_vend[k]   = 1'b0;
            m_pay[k]    = 1'b0;
            m_rej[k]    = 1'b0;
        end else begin
            if (m_vend[k]) begin
                m_credit[k] -= PRICE;
                m_stock[k]  -= 1;
                m_vend[k]    = 1'b0;
                m_pay[k]     = (m_credit[k] > 0);
            end else if (m_pay[k]) begin
                m_credit[k] -= 1;
                m_pay[k]     = (m_credit[k] > 0);
            end else begin
                idle   = (m_credit[k] == 0);
                accept = present && (m_stock[k] != 0) && !can && (m_credit[k] + val <= MAXC);
                if (idle && rs) m_stock[k] = si[k];
                if (accept) begin
                    m_credit[k] += val;
                    m_vend[k]    = (m_credit[k] >= PRICE);
                end else if (can && !idle) begin
                    m_pay[k] = 1'b1;
                end
            end
            m_rej[k] = present && !accept;
        end
    endtask

    task automatic check_unit(input int k, input logic disp, input logic chg, input logic rej,
                              input logic [CW-1:0] cr, input logic [SW-1:0] st,
                              input logic so, input logic bz);
        string p;
        p = (k == 0) ? "u0" : "u1";
        chk({p, " dispense"},     disp, m_vend[k]);
        chk({p, " change_pulse"}, chg,  m_pay[k]);
        chk({p, " coin_reject"},  rej,  m_rej[k]);
        chk({p, " credit"},       cr,   m_credit[k]);
        chk({p, " stock"},        st,   m_stock[k]);
        chk({p, " sold_out"},     so,   (m_stock[k] == 0));
        chk({p, " busy"},         bz,   (m_vend[k] || m_pay[k]));
        if (disp === 1'b1) disp_cnt[k]++;
        if (chg === 1'b1)  chg_cnt[k]++;
    endtask

    task automatic step(input logic cv, input logic [1:0] c, input logic can,
                        input logic rs, input logic rr);
        bus0.coin_valid = cv;  bus1.coin_valid = cv;
        bus0.coin       = c;   bus1.coin       = c;
        bus0.cancel     = can; bus1.cancel     = can;
        bus0.restock    = rs;  bus1.restock    = rs;
        rst             = rr;
        @(posedge clk);
        model_tick(0, cv, c, can, rs, rr);
        model_tick(1, cv, c, can, rs, rr);
        #1;
        check_unit(0, bus0.dispense, bus0.change_pulse, bus0.coin_reject,
                   bus0.credit, bus0.stock, bus0.sold_out, bus0.busy);
        check_unit(1, bus1.dispense, bus1.change_pulse, bus1.coin_reject,
                   bus1.credit, bus1.stock, bus1.sold_out, bus1.busy);
    endtask

    task automatic coin(input logic [1:0] c);
        step(1'b1, c, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        disp_cnt = '{0, 0};
        chg_cnt  = '{0, 0};
    endtask

    initial begin
        m_credit = '{0, 0};
        m_stock  = '{0, 0};
        m_vend   = '{0, 0};
        m_pay    = '{0, 0};
        m_rej    = '{0, 0};
        clr_counts();

        // Reset state
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("reset credit", bus0.credit, 0);
        chk("reset stock u0", bus0.stock, 8);
        chk("reset stock u1", bus1.stock, 1);
        idle_n(1);

        // Two 2-unit coins reach the price exactly: one vend, no change
        clr_counts();
        coin(2'b10);
        chk("t1 credit after first coin", bus0.credit, 2);
        coin(2'b10);
        chk("t1 dispense latency", bus0.dispense, 1);
        chk("t1 credit at vend", bus0.credit, 4);
        idle_n(2);
        chk("t1 dispense count", disp_cnt[0], 1);
        chk("t1 change count", chg_cnt[0], 0);
        chk("t1 stock", bus0.stock, 7);
        chk("t1 credit", bus0.credit, 0);
        chk("t5 sold_out after vend", bus1.sold_out, 1);

        // Sold-out unit refuses a coin, restock in IDLE, coin then accepted
        coin(2'b01);
        chk("t5 sold-out reject", bus1.coin_reject, 1);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle_n(1);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("t5 restock stock", bus1.stock, 1);
        coin(2'b01);
        chk("t5 accepted credit", bus1.credit, 1);
        chk("t5 no reject", bus1.coin_reject, 0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle_n(2);

        // 1 + 4 units: vend with one change pulse
        clr_counts();
        coin(2'b01);
        coin(2'b11);
        chk("t2 credit at vend", bus0.credit, 5);
        idle_n(3);
        chk("t2 dispense count", disp_cnt[0], 1);
        chk("t2 change count", chg_cnt[0], 1);
        chk("t2 busy", bus0.busy, 0);

        // Cancel after 2 units, coin during CHANGE refused
        clr_counts();
        coin(2'b10);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        coin(2'b11);
        chk("t4 reject in change", bus0.coin_reject, 1);
        idle_n(2);
        chk("t3 change count", chg_cnt[0], 2);
        chk("t3 dispense count", disp_cnt[0], 0);
        chk("t3 credit", bus0.credit, 0);

        // Coin with cancel: cancel wins, coin refused
        coin(2'b01);
        step(1'b1, 2'b11, 1'b1, 1'b0, 1'b0);
        chk("t4 reject with cancel", bus0.coin_reject, 1);
        chk("t4 credit unaffected", bus0.credit, 1);
        idle_n(2);

        // Reset on the 2nd cycle of a 3-unit refund
        coin(2'b01);
        coin(2'b10);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle_n(1);
        chk("t6 second change cycle", bus0.change_pulse, 1);
        clr_counts();
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle_n(3);
        chk("t6 change after reset", chg_cnt[0], 0);
        chk("t6 credit", bus0.credit, 0);
        chk("t6 stock u0", bus0.stock, 8);
        chk("t6 stock u1", bus1.stock, 1);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
